wb_bus_arbiter: RTL
===================

// Module: wb_bus_arbiter
// PURPOSE
//  Two-master round-robin Wishbone (classic) arbiter inside soc. Shares the single internal slave bus
//  between master 0 (Caravel host wishbone port, caravel_wbs_*) and master 1 (on-chip CPU data port).
//  Grant is locked for a whole bus cycle (cyc high). Slave side feeds the soc address decoder.
// PARAMETERS
//  ADDR_W          32   address width per master
//  DATA_W          32   data width; SEL_W = DATA_W/8
//  TIMEOUT_CYCLES  255  stall limit in cycles (used only with WB_ARB_TIMEOUT_EN)
// PORTS
//  clk_i      in   1         single clock
//  rst_i      in   1         synchronous reset, active-high
//  m_cyc_i    in   2         per-master cyc, bit0 = Caravel host, bit1 = CPU
//  m_stb_i    in   2         per-master stb
//  m_we_i     in   2         per-master write enable
//  m_sel_i    in   2*SEL_W   per-master byte selects, master n at [n*SEL_W +: SEL_W]
//  m_adr_i    in   2*ADDR_W  per-master address, packed as above
//  m_dat_i    in   2*DATA_W  per-master write data, packed as above
//  m_ack_o    out  2         ack routed to granted master only
//  m_err_o    out  2         timeout error (tied 0 without WB_ARB_TIMEOUT_EN)
//  m_dat_o    out  DATA_W    read data, broadcast to both masters (qualify with ack)
//  s_cyc_o / s_stb_o / s_we_o  out 1   slave bus controls
//  s_sel_o    out  SEL_W     slave byte selects
//  s_adr_o    out  ADDR_W    slave address
//  s_dat_o    out  DATA_W    slave write data
//  s_ack_i    in   1         slave ack
//  s_dat_i    in   DATA_W    slave read data
//  grant_o    out  2         one-hot current grant (debug, LA-visible)
// BEHAVIOUR
//  - Reset: state IDLE, grant_o=00, s_cyc_o=s_stb_o=0, m_ack_o=m_err_o=00, priority pointer -> master 0.
//  - FSM IDLE / BUSY (/ ABORT with timeout). IDLE: if any m_cyc_i, register grant at the edge -> BUSY.
//  - Latency: request sampled cycle N -> s_cyc_o high cycle N+1. Slave-side outputs are combinational
//    muxes of granted master, forced to 0 when not BUSY; m_ack_o[g] = s_ack_i & BUSY, other bit 0.
//  - Round-robin: both requesting in IDLE -> pointer master wins; after each grant pointer moves to the
//    other master. Single requester always wins regardless of pointer.
//  - BUSY held while m_cyc_i[g]=1; when it drops -> IDLE at next edge (one dead cycle), then re-arbitrate.
//    Back-to-back from same master with other idle: 1 dead cycle between cycles.
//  - Non-granted master waits with stb held; it sees no ack. s_ack_i outside BUSY is ignored.
//  - s_ack_i and m_cyc_i[g] drop in same cycle: ack still delivered that cycle, then IDLE.
//  - rst_i mid-transaction: all outputs return to reset values at the next edge; no ack emitted.
// CONFIGURATION
//  WB_ARB_TIMEOUT_EN defined: 8+ bit counter (width $clog2(TIMEOUT_CYCLES+1)) counts cycles with
//  s_stb_o=1 & s_ack_i=0, cleared on ack or leaving BUSY. On reaching TIMEOUT_CYCLES: m_err_o[g]
//  pulses 1 cycle, state -> ABORT (s_cyc_o/s_stb_o=0) until m_cyc_i[g]=0, then IDLE.
//  Undefined: no counter, no ABORT state, m_err_o=00 constant, stalled slave holds bus indefinitely.
// STRUCTURE
//  - wb_arb_pkg: state enum (ARB_IDLE, ARB_BUSY, ARB_ABORT), MST_CARAVEL=0, MST_CPU=1, NUM_MST=2.
//  - Sub-module wb_arb_rr_pick: combinational round-robin picker (req[1:0], ptr -> one-hot gnt).
//  - Top: FSM, grant/pointer regs, slave mux, ack/err demux, optional timeout counter.
// TESTING
//  1 Reset: rst_i=1 two cycles with both cyc high -> grant_o=00, s_cyc_o=0, m_ack_o=00 throughout.
//  2 Single write: m0 cyc/stb, adr=0x3000_0004, dat=0xA5A5_0001, sel=F at cycle N -> s_cyc_o and
//    s_adr_o=0x3000_0004 at N+1; s_ack_i at N+3 -> m_ack_o=01 same cycle.
//  3 Contention after reset: both request same cycle -> master 0 granted; m0 drops cyc -> IDLE one
//    cycle -> master 1 granted; both persist -> grants alternate 01,10,01.
//  4 Read: m1 reads adr 0x0000_0100, slave returns s_dat_i=0xDEAD_BEEF with ack -> m_dat_o=0xDEAD_BEEF,
//    m_ack_o=10; m_ack_o[0] stays 0 while m0 waits.
//  5 Reset mid-cycle: rst_i during BUSY before ack -> next edge s_cyc_o=0, grant_o=00; late s_ack_i ignored.
//  6 Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): no s_ack_i -> m_err_o[g] pulse after 16 stall
//    cycles, s_cyc_o low until master drops cyc; without macro: no err, bus held 100+ cycles.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone round-robin arbiter.
package wb_arb_pkg;

  localparam int NUM_MST = 2;

  // Master indices; one bit is enough to name a master when NUM_MST is 2.
  localparam logic MST_CARAVEL = 1'b0;
  localparam logic MST_CPU     = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_ABORT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// Wishbone bundle between the two masters, the arbiter and the shared slave bus.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface wb_bus_arbiter_if
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  localparam int SEL_W = DATA_W / 8;

  logic [NUM_MST-1:0]        m_cyc_i;
  logic [NUM_MST-1:0]        m_stb_i;
  logic [NUM_MST-1:0]        m_we_i;
  logic [NUM_MST*SEL_W-1:0]  m_sel_i;
  logic [NUM_MST*ADDR_W-1:0] m_adr_i;
  logic [NUM_MST*DATA_W-1:0] m_dat_i;
  logic [NUM_MST-1:0]        m_ack_o;
  logic [NUM_MST-1:0]        m_err_o;
  logic [DATA_W-1:0]         m_dat_o;
  logic                      s_cyc_o;
  logic                      s_stb_o;
  logic                      s_we_o;
  logic [SEL_W-1:0]          s_sel_o;
  logic [ADDR_W-1:0]         s_adr_o;
  logic [DATA_W-1:0]         s_dat_o;
  logic                      s_ack_i;
  logic [DATA_W-1:0]         s_dat_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    input  m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );

endinterface

// File: rtl/wb_bus_arbiter_rr_pick.sv
// Combinational two-way round-robin picker: a lone requester always wins,
// a tie goes to the master named by the priority pointer.
module wb_arb_rr_pick
  import wb_arb_pkg::*;
(
  input  logic [NUM_MST-1:0] i_req,
  input  logic               i_ptr,
  output logic [NUM_MST-1:0] o_gnt
);

  always_comb begin
    o_gnt = '0;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (i_ptr == MST_CPU) ? 2'b10 : 2'b01;
      default: o_gnt = '0;
    endcase
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master round-robin Wishbone classic arbiter; grant is held for a whole bus cycle.
// Optional stall timeout with error pulse and abort: define WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  wb_bus_arbiter_if.slave    bus,
  output logic [NUM_MST-1:0] grant_o
);

  localparam int SEL_W = DATA_W / 8;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("wb_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e         r_state, w_state_nxt;
  logic [NUM_MST-1:0] r_grant, w_grant_nxt, w_pick;
  logic               r_ptr, w_ptr_nxt;
  logic               w_gidx, w_busy, w_err;

  wb_arb_rr_pick u_pick (
    .i_req (bus.m_cyc_i),
    .i_ptr (r_ptr),
    .o_gnt (w_pick)
  );

  assign w_gidx  = r_grant[MST_CPU];
  assign w_busy  = (r_state == ARB_BUSY);
  assign grant_o = r_grant;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_ptr   <= MST_CARAVEL;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ARB_IDLE: begin
        if (|bus.m_cyc_i) begin
          w_state_nxt = ARB_BUSY;
          w_grant_nxt = w_pick;
          // Priority passes to whichever master did not just win.
          w_ptr_nxt   = w_pick[MST_CARAVEL] ? MST_CPU : MST_CARAVEL;
        end
      end
      ARB_BUSY: begin
        if (w_err) begin
          w_state_nxt = ARB_ABORT;
        end else if (!bus.m_cyc_i[w_gidx]) begin
          w_state_nxt = ARB_IDLE;
          w_grant_nxt = '0;
        end
      end
      ARB_ABORT: begin
        if (!bus.m_cyc_i[w_gidx]) begin
          w_state_nxt = ARB_IDLE;
          w_grant_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // Slave side follows the granted master only while BUSY; idle/abort park the bus at zero.
  assign bus.s_cyc_o = w_busy & bus.m_cyc_i[w_gidx];
  assign bus.s_stb_o = w_busy & bus.m_stb_i[w_gidx];
  assign bus.s_we_o  = w_busy & bus.m_we_i[w_gidx];
  assign bus.s_sel_o = w_busy ? bus.m_sel_i[w_gidx*SEL_W +: SEL_W]   : '0;
  assign bus.s_adr_o = w_busy ? bus.m_adr_i[w_gidx*ADDR_W +: ADDR_W] : '0;
  assign bus.s_dat_o = w_busy ? bus.m_dat_i[w_gidx*DATA_W +: DATA_W] : '0;

  assign bus.m_ack_o = r_grant & {NUM_MST{w_busy & bus.s_ack_i}};
  assign bus.m_dat_o = bus.s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_tmo_cnt;

  // Counts strobed-but-unacked cycles; saturates so the error cannot re-fire by wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i || !w_busy || bus.s_ack_i) begin
      r_tmo_cnt <= '0;
    end else if (bus.s_stb_o && (r_tmo_cnt != TMO_MAX)) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_err       = w_busy & ~bus.s_ack_i & (r_tmo_cnt == TMO_MAX);
  assign bus.m_err_o = r_grant & {NUM_MST{w_err}};
`else
  assign w_err       = 1'b0;
  assign bus.m_err_o = '0;
`endif

endmodule
